uart_tx_arbiter: RTL and testbench

//   Round-robin, packet-locking arbiter that shares one uart_tx byte transmitter between NUM_REQ

---
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one byte-wide UART transmitter between
// NUM_REQ byte-stream requesters over a tx_start/tx_busy handshake.
module uart_tx_arbiter #(
  parameter  int NUM_REQ       = 4,
  parameter  int MAX_PKT_BYTES = 64,
  parameter  int IDLE_TIMEOUT  = 1024,
  parameter  int BUSY_WAIT     = 4,
  localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id,
  output logic                 timeout_evt,
  output logic                 busy_err
);

  localparam int ICW = $clog2(IDLE_TIMEOUT + 1);
  localparam int BWW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [2:0] {ARB, LOAD, WAIT_HI, WAIT_LO, HOLD} state_t;

  state_t                    state;
  logic [IDW-1:0]            rr_ptr;
  logic [7:0]                byte_cnt;
  logic [ICW-1:0]            idle_cnt;
  logic [BWW-1:0]            bw_cnt;
  logic                      last_flag;

  logic [NUM_REQ-1:0][7:0]   req_byte;
  logic                      win_vld;
  logic [IDW-1:0]            win_id;
  logic [IDW-1:0]            nxt_ptr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_byte[i] = req_data[8*i +: 8];
  end

  // Rotating scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  // The just-released holder drops to lowest priority on the next scan.
  assign nxt_ptr = (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB;
      rr_ptr      <= '0;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      bw_cnt      <= '0;
      last_flag   <= 1'b0;
      req_ready   <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout_evt <= 1'b0;
      busy_err    <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      req_ready   <= '0;
      timeout_evt <= 1'b0;
      case (state)
        ARB: begin
          if (win_vld) begin
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            tx_data     <= req_byte[win_id];
            tx_start    <= 1'b1;
            req_ready   <= NUM_REQ'(1) << win_id;
            byte_cnt    <= 8'd1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          bw_cnt    <= '0;
          last_flag <= req_last[grant_id] || (byte_cnt == 8'(MAX_PKT_BYTES));
          state     <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (bw_cnt == BWW'(BUSY_WAIT-1)) begin
            busy_err    <= 1'b1;
            grant_valid <= 1'b0;
            rr_ptr      <= nxt_ptr;
            byte_cnt    <= '0;
            state       <= ARB;
          end else begin
            bw_cnt <= bw_cnt + BWW'(1);
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (last_flag) begin
              grant_valid <= 1'b0;
              rr_ptr      <= nxt_ptr;
              byte_cnt    <= '0;
              state       <= ARB;
            end else begin
              idle_cnt <= '0;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (req_valid[grant_id]) begin
            tx_data   <= req_byte[grant_id];
            tx_start  <= 1'b1;
            req_ready <= NUM_REQ'(1) << grant_id;
            byte_cnt  <= byte_cnt + 8'd1;
            state     <= LOAD;
          end else if (idle_cnt == ICW'(IDLE_TIMEOUT-1)) begin
            timeout_evt <= 1'b1;
            grant_valid <= 1'b0;
            rr_ptr      <= nxt_ptr;
            byte_cnt    <= '0;
            state       <= ARB;
          end else begin
            idle_cnt <= idle_cnt + ICW'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a byte-timed 115200-baud transmitter model.
module tb_uart_tx_arbiter;

  localparam int NR        = 4;
  localparam int BYTE_CLKS = 434 * 10;
  localparam int LIM       = 40000;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          grant_valid;
  logic [1:0]    grant_id;
  logic          timeout_evt;
  logic          busy_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_PKT_BYTES(4), .IDLE_TIMEOUT(16), .BUSY_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .grant_valid(grant_valid), .grant_id(grant_id),
    .timeout_evt(timeout_evt), .busy_err(busy_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Transmitter: busy rises the cycle after tx_start is sampled, held for one 10-bit frame.
  logic model_busy;
  int   bcnt;
  logic busy_stub;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      bcnt       <= 0;
    end else if (tx_start && !model_busy) begin
      model_busy <= 1'b1;
      bcnt       <= BYTE_CLKS - 1;
    end else if (model_busy) begin
      if (bcnt == 0) model_busy <= 1'b0;
      else           bcnt <= bcnt - 1;
    end
  end
  assign tx_busy = busy_stub ? 1'b0 : model_busy;

  typedef struct packed { logic [1:0] id; logic [7:0] d; } exp_t;
  exp_t sb[$];

  int n_chk, n_err;
  int falls, tmo_cnt, starts;
  int clr_gen;
  logic [8:0] mem [NR][32];
  int hd [NR];
  int tl [NR];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic enq(input int r, input logic [7:0] d, input logic l);
    mem[r][tl[r]] = {l, d};
    tl[r]++;
  endtask

  task automatic push_exp(input int r, input logic [7:0] d);
    exp_t e;
    e.id = 2'(r);
    e.d  = d;
    sb.push_back(e);
  endtask

  function automatic bit q_empty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (hd[i] != tl[i]) e = 1'b0;
    return e;
  endfunction

  // Requester models: present queued bytes, advance on an accepted byte.
  initial begin
    logic [NR-1:0] acc;
    int seen_gen;
    seen_gen = 0;
    for (int i = 0; i < NR; i++) hd[i] = 0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (seen_gen != clr_gen) hd[i] = tl[i];
        else if (acc[i] && hd[i] < tl[i]) hd[i]++;
        req_valid[i]       = (hd[i] < tl[i]);
        req_data[8*i +: 8] = mem[i][hd[i]][7:0];
        req_last[i]        = mem[i][hd[i]][8];
      end
      seen_gen = clr_gen;
    end
  end

  // Output monitor: every tx_start pops one expectation.
  initial begin
    logic pst, pbusy;
    exp_t e;
    pst = 1'b0;
    pbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (pbusy && !tx_busy) falls++;
      pbusy = tx_busy;
      if (timeout_evt) tmo_cnt++;
      if (pst) chk("start_width", 32'(tx_start), 0);
      if (tx_start) begin
        starts++;
        if (sb.size() == 0) chk("sb_unexpected", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("tx_data", tx_data, e.d);
          chk("grant_id", grant_id, e.id);
          chk("req_ready", req_ready, 4'b0001 << e.id);
          chk("grant_vld", grant_valid, 1);
        end
      end else if (req_ready != '0) chk("ready_no_start", req_ready, 0);
      pst = tx_start;
    end
  end

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_timeout", timeout_evt, 0);
    chk("rst_busy_err", busy_err, 0);
    clr_gen++;
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (c < LIM && !(q_empty() && sb.size() == 0 && !grant_valid && !tx_busy)) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(c < LIM), 1);
  endtask

  initial begin
    int c, f0, t0, s0;
    n_chk = 0; n_err = 0; falls = 0; tmo_cnt = 0; starts = 0; clr_gen = 0;
    busy_stub = 1'b0;
    for (int i = 0; i < NR; i++) tl[i] = 0;
    do_reset();
    release_reset();

    // 1: three-byte packet from requester 1
    f0 = falls;
    enq(1, 8'h41, 0); enq(1, 8'h42, 0); enq(1, 8'h43, 1);
    push_exp(1, 8'h41); push_exp(1, 8'h42); push_exp(1, 8'h43);
    c = 0;
    while (c < 50 && !grant_valid) begin @(negedge clk); c++; end
    chk("t1_grant", grant_valid, 1);
    c = 0;
    while (c < LIM && grant_valid) begin
      @(negedge clk); c++;
      if (grant_valid) chk("t1_gid_hold", grant_id, 1);
    end
    chk("t1_falls_at_drop", falls - f0, 3);
    chk("t1_gid_kept", grant_id, 1);
    wait_idle("t1_idle");

    // 2: simultaneous single-byte packets from reset
    do_reset();
    enq(0, 8'h10, 1); enq(2, 8'h12, 1); enq(3, 8'h13, 1);
    push_exp(0, 8'h10); push_exp(2, 8'h12); push_exp(3, 8'h13);
    release_reset();
    wait_idle("t2_idle");
    chk("t2_last_gid", grant_id, 3);

    // 3: length cap on requester 2, requester 1 slips in between
    t0 = tmo_cnt;
    for (int b = 1; b <= 6; b++) enq(2, 8'(8'h20 + b), b == 6);
    for (int b = 1; b <= 4; b++) push_exp(2, 8'(8'h20 + b));
    push_exp(1, 8'h5A);
    push_exp(2, 8'h25); push_exp(2, 8'h26);
    c = 0;
    while (c < 50 && !(grant_valid && grant_id == 2'd2)) begin @(negedge clk); c++; end
    chk("t3_grant2", 32'(c < 50), 1);
    enq(1, 8'h5A, 1);
    wait_idle("t3_idle");
    chk("t3_no_timeout", tmo_cnt - t0, 0);

    // 4: requester 3 stalls after one byte without last
    enq(3, 8'h77, 0);
    push_exp(3, 8'h77);
    c = 0;
    while (c < 100 && !tx_busy) begin @(negedge clk); c++; end
    chk("t4_busy_rise", 32'(c < 100), 1);
    c = 0;
    while (c < LIM && tx_busy) begin @(negedge clk); c++; end
    c = 0;
    while (c < 64 && !timeout_evt) begin @(negedge clk); c++; end
    chk("t4_timeout_lat", c, 17);
    chk("t4_grant_dropped", grant_valid, 0);
    @(negedge clk);
    chk("t4_timeout_width", timeout_evt, 0);
    wait_idle("t4_idle");

    // 5: transmitter never goes busy
    busy_stub = 1'b1;
    enq(0, 8'h55, 1);
    push_exp(0, 8'h55);
    c = 0;
    while (c < 50 && !tx_start) begin @(negedge clk); c++; end
    chk("t5_start", tx_start, 1);
    c = 0;
    while (c < 20 && !busy_err) begin @(negedge clk); c++; end
    chk("t5_err_lat", c, 5);
    chk("t5_grant_dropped", grant_valid, 0);
    repeat (20) @(negedge clk);
    chk("t5_err_sticky", busy_err, 1);
    do_reset();
    busy_stub = 1'b0;
    release_reset();

    // 6: reset while a byte from requester 1 is on the wire
    enq(1, 8'h31, 1);
    push_exp(1, 8'h31);
    c = 0;
    while (c < 100 && !tx_busy) begin @(negedge clk); c++; end
    chk("t6_busy_rise", tx_busy, 1);
    repeat (2) @(negedge clk);
    do_reset();
    enq(0, 8'hA0, 1); enq(1, 8'hA1, 1); enq(2, 8'hA2, 1); enq(3, 8'hA3, 1);
    push_exp(0, 8'hA0);
    s0 = starts;
    release_reset();
    c = 0;
    while (c < 50 && starts == s0) begin @(negedge clk); c++; end
    chk("t6_first_start", 32'(starts - s0), 1);
    chk("t6_sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
